// File: rtl/aurora_rst_pkg.sv
// Shared definitions for the Aurora link reset sequencer: state encoding and
// the width helper used to size its counters.
package aurora_rst_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_GT_RST    = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_CORE_RST  = 3'd2,
        S_WAIT_LINK = 3'd3,
        S_UP        = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous status inputs.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make meta and q a true two-stage shift;
    // blocking ones would collapse the chain into a single flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/aurora_reset_sequencer.sv
// Supervised bring-up of one Aurora link: GT reset, PLL lock, core reset,
// stable channel_up, with bounded retries before a sticky fault.
module aurora_reset_sequencer
    import aurora_rst_pkg::*;
#(
    parameter int GT_RST_CYCLES   = 16,
    parameter int CORE_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 1024,
    parameter int LINK_TIMEOUT    = 65535,
    parameter int UP_STABLE       = 64,
    parameter int MAX_RETRY       = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_lock,
    input  logic               channel_up,
    output logic               gt_reset,
    output logic               core_reset,
    output logic               link_ready,
    output logic               fault,
    output logic [3:0]         retry_count,
    output logic [STATE_W-1:0] state
);

    localparam int MAX_A     = (GT_RST_CYCLES > CORE_RST_CYCLES) ? GT_RST_CYCLES : CORE_RST_CYCLES;
    localparam int MAX_B     = (LOCK_TIMEOUT > LINK_TIMEOUT) ? LOCK_TIMEOUT : LINK_TIMEOUT;
    localparam int MAX_DWELL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W     = clog2(MAX_DWELL);
    localparam int STB_W     = clog2(UP_STABLE);

    localparam logic [CNT_W-1:0] GT_LAST   = CNT_W'(GT_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LINK_LAST = CNT_W'(LINK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST  = STB_W'(UP_STABLE - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    logic             lock_s;
    logic             up_s;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [STB_W-1:0] stb_q;
    logic [3:0]       retry_d;
    logic             timeout;
    logic             counting;
    logic             gt_reset_d;
    logic             core_reset_d;
    logic             link_ready_d;
    logic             fault_d;

    sync_2ff u_sync_lock (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    sync_2ff u_sync_up (
        .clk (clk),
        .rst (rst),
        .d   (channel_up),
        .q   (up_s)
    );

    // NOTE: every signal gets its default before the case so that no path
    // through this block leaves a value unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        retry_d = retry_count;
        timeout = 1'b0;

        case (state_q)
            S_GT_RST: begin
                if (cnt_q == GT_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s)                  state_d = S_CORE_RST;
                else if (cnt_q == LOCK_LAST) timeout = 1'b1;
            end
            S_CORE_RST: begin
                if (!lock_s)                 timeout = 1'b1;
                else if (cnt_q == CORE_LAST) state_d = S_WAIT_LINK;
            end
            S_WAIT_LINK: begin
                if (!lock_s)                        timeout = 1'b1;
                else if (up_s && stb_q == STB_LAST) state_d = S_UP;
                else if (cnt_q == LINK_LAST)        timeout = 1'b1;
            end
            S_UP: begin
                if (!up_s || !lock_s) state_d = S_GT_RST;
            end
            S_FAULT: ;
            default: state_d = S_GT_RST;
        endcase

        // Timeouts and lock losses share one retry budget; link loss from S_UP does not.
        if (timeout) begin
            if (retry_count == RETRY_MAX) begin
                state_d = S_FAULT;
            end else begin
                retry_d = retry_count + 4'd1;
                state_d = S_GT_RST;
            end
        end

        if (state_d == S_UP && state_q != S_UP) retry_d = 4'd0;

        gt_reset_d   = (state_d == S_GT_RST) || (state_d == S_FAULT);
        core_reset_d = state_d inside {S_GT_RST, S_WAIT_LOCK, S_CORE_RST, S_FAULT};
        link_ready_d = (state_d == S_UP);
        fault_d      = (state_d == S_FAULT);
    end

    assign counting = state_q inside {S_GT_RST, S_WAIT_LOCK, S_CORE_RST, S_WAIT_LINK};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_GT_RST;
            cnt_q       <= '0;
            stb_q       <= '0;
            retry_count <= 4'd0;
            gt_reset    <= 1'b1;
            core_reset  <= 1'b1;
            link_ready  <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_d;
            retry_count <= retry_d;
            gt_reset    <= gt_reset_d;
            core_reset  <= core_reset_d;
            link_ready  <= link_ready_d;
            fault       <= fault_d;

            if (state_d != state_q || !counting) cnt_q <= '0;
            else                                 cnt_q <= cnt_q + 1'b1;

            if (state_d != state_q || state_q != S_WAIT_LINK || !up_s) stb_q <= '0;
            else                                                       stb_q <= stb_q + 1'b1;
        end
    end

    assign state = state_q;

endmodule
